// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEBOUNCE_DEFAULT_COUNTS = 2500;
  localparam int HOLD_DEFAULT_COUNTS     = CLK_HZ;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, stability counter, hold counter
// and optional auto-repeat, all with registered outputs.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DELAY_COUNTS  = DEBOUNCE_DEFAULT_COUNTS,
  parameter int HOLD_COUNTS   = HOLD_DEFAULT_COUNTS,
  parameter int REPEAT_COUNTS = 0,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic button_pressed,
  output logic button_edge,
  output logic button_release,
  output logic long_press,
  output logic held,
  output logic repeat_pulse
);

  localparam int DW = cnt_width(DELAY_COUNTS);
  localparam int HW = cnt_width(HOLD_COUNTS);
  localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY_COUNTS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNTS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_COUNTS);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0] stab_cnt_q, stab_cnt_d;
  logic          pressed_q, pressed_d;
  logic          edge_q, edge_d, release_q, release_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_q, long_d, held_q, held_d;
  logic          accept, fall;

  always_comb begin
    sync1_d   = button ^ ACTIVE_LOW;
    sync2_d   = sync1_q;
    accept    = (sync2_q != pressed_q) && (stab_cnt_q == DLY_LAST);
    fall      = accept && pressed_q;
    pressed_d = pressed_q ^ accept;
    edge_d    = accept && !pressed_q;
    release_d = fall;

    // Any sample matching the accepted level restarts the stability window.
    if ((sync2_q == pressed_q) || accept) stab_cnt_d = '0;
    else                                  stab_cnt_d = stab_cnt_q + DW'(1);

    if (!pressed_q)                  hold_cnt_d = '0;
    else if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HW'(1);
    else                             hold_cnt_d = hold_cnt_q;

    long_d = pressed_q && !fall && (hold_cnt_q == HOLD_LAST);
    held_d = (held_q || long_d) && !fall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stab_cnt_q <= '0;
      pressed_q  <= 1'b0;
      edge_q     <= 1'b0;
      release_q  <= 1'b0;
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stab_cnt_q <= stab_cnt_d;
      pressed_q  <= pressed_d;
      edge_q     <= edge_d;
      release_q  <= release_d;
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
      held_q     <= held_d;
    end
  end

  assign button_pressed = pressed_q;
  assign button_edge    = edge_q;
  assign button_release = release_q;
  assign long_press     = long_q;
  assign held           = held_q;

  if (REPEAT_COUNTS > 0) begin : g_repeat
    localparam int RW = cnt_width(REPEAT_COUNTS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_COUNTS - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_q, rep_d;

    // Wrapping at REPEAT_COUNTS-1 gives one pulse every REPEAT_COUNTS cycles.
    always_comb begin
      rep_cnt_d = '0;
      rep_d     = 1'b0;
      if (held_q) begin
        rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + RW'(1);
        rep_d     = (rep_cnt_q == REP_LAST) && !fall;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_q <= '0;
        rep_q     <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        rep_q     <= rep_d;
      end
    end

    assign repeat_pulse = rep_q;
  end else begin : g_no_repeat
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent debounce channels sharing one clock and reset.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DELAY_COUNTS  = DEBOUNCE_DEFAULT_COUNTS,
  parameter int HOLD_COUNTS   = HOLD_DEFAULT_COUNTS,
  parameter int REPEAT_COUNTS = 0,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] button_pressed,
  output logic [N_CH-1:0] button_edge,
  output logic [N_CH-1:0] button_release,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DELAY_COUNTS (DELAY_COUNTS),
      .HOLD_COUNTS  (HOLD_COUNTS),
      .REPEAT_COUNTS(REPEAT_COUNTS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .button        (button[i]),
      .button_pressed(button_pressed[i]),
      .button_edge   (button_edge[i]),
      .button_release(button_release[i]),
      .long_press    (long_press[i]),
      .held          (held[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: window-based reference model, table vectors,
// directed corner sequences and an ACTIVE_LOW / no-repeat instance.
module tb_debounce_multi;

  localparam int N    = 2;
  localparam int DLY  = 8;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] button = 2'b00;
  logic [0:0] al_button = 1'b1;

  logic [1:0] pressed, bedge, brel, lp, hld, rep;
  logic [0:0] al_pressed, al_edge, al_rel, al_lp, al_held, al_rep;

  int checks = 0;
  int failures = 0;
  int model_fail_prints = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH(N), .DELAY_COUNTS(DLY), .HOLD_COUNTS(HOLD), .REPEAT_COUNTS(REP), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .button_pressed(pressed), .button_edge(bedge), .button_release(brel),
    .long_press(lp), .held(hld), .repeat_pulse(rep)
  );

  debounce_multi #(
    .N_CH(1), .DELAY_COUNTS(2500), .HOLD_COUNTS(HOLD), .REPEAT_COUNTS(0), .ACTIVE_LOW(1'b1)
  ) u_al (
    .clk(clk), .rst_n(rst_n), .button(al_button),
    .button_pressed(al_pressed), .button_edge(al_edge), .button_release(al_rel),
    .long_press(al_lp), .held(al_held), .repeat_pulse(al_rep)
  );

  // Reference model: a level is accepted once the last DLY synchronised
  // samples all differ from it; pulses follow from the age of the press.
  bit         hist [N][DLY+2];
  logic [1:0] m_pressed, m_edge, m_rel, m_long, m_held, m_rep;
  int         m_age [N];

  task automatic model_reset();
    m_pressed = '0; m_edge = '0; m_rel = '0; m_long = '0; m_held = '0; m_rep = '0;
    for (int c = 0; c < N; c++) begin
      m_age[c] = 0;
      for (int k = 0; k < DLY + 2; k++) hist[c][k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit all_diff;
      for (int k = DLY + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = button[c];
      all_diff = 1'b1;
      for (int k = 2; k < DLY + 2; k++)
        if (hist[c][k] == m_pressed[c]) all_diff = 1'b0;
      m_edge[c] = 1'b0;
      m_rel[c]  = 1'b0;
      if (all_diff) begin
        m_edge[c]    = !m_pressed[c];
        m_rel[c]     = m_pressed[c];
        m_pressed[c] = !m_pressed[c];
        m_age[c]     = 0;
      end else if (m_pressed[c]) begin
        m_age[c]++;
      end
      m_long[c] = m_pressed[c] && (m_age[c] == HOLD);
      m_held[c] = m_pressed[c] && (m_age[c] >= HOLD);
      m_rep[c]  = m_pressed[c] && (m_age[c] > HOLD) && (((m_age[c] - HOLD) % REP) == 0);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({pressed, bedge, brel, lp, hld, rep} !== {m_pressed, m_edge, m_rel, m_long, m_held, m_rep}) begin
      failures++;
      if (model_fail_prints < 20) begin
        model_fail_prints++;
        $display("FAIL model t=%0t got p=%b e=%b r=%b l=%b h=%b rp=%b want p=%b e=%b r=%b l=%b h=%b rp=%b",
                 $time, pressed, bedge, brel, lp, hld, rep,
                 m_pressed, m_edge, m_rel, m_long, m_held, m_rep);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] btn;
    int         cycles;
    logic [1:0] exp_p;
    logic [1:0] exp_h;
  } vec_t;

  vec_t tbl [8];
  int   n_edge, n_rel, n_long, n_held, edge_at, rel_at, long_at, al_rise_at, al_rep_seen, al_edges;
  bit   b0;
  bit   rb [N];
  int   run_left [N];

  initial begin
    tbl[0] = '{2'b01, 12, 2'b01, 2'b00};
    tbl[1] = '{2'b11, 12, 2'b11, 2'b00};
    tbl[2] = '{2'b11, 10, 2'b11, 2'b01};
    tbl[3] = '{2'b10, 12, 2'b10, 2'b10};
    tbl[4] = '{2'b00,  5, 2'b10, 2'b10};
    tbl[5] = '{2'b00, 10, 2'b00, 2'b00};
    tbl[6] = '{2'b01,  5, 2'b00, 2'b00};
    tbl[7] = '{2'b00, 12, 2'b00, 2'b00};

    // Reset state
    #3;
    chk("reset_outputs", {pressed, bedge, brel, lp, hld, rep}, 0);
    do_reset();

    // Table-driven level/held sequence
    foreach (tbl[i]) begin
      button = tbl[i].btn;
      cyc(tbl[i].cycles);
      chk($sformatf("tbl%0d_pressed", i), pressed, tbl[i].exp_p);
      chk($sformatf("tbl%0d_held", i), hld, tbl[i].exp_h);
    end

    // Clean press on channel 0, channel 1 quiet
    button = 2'b00;
    do_reset();
    @(negedge clk);
    button = 2'b01;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk("clean_edge", bedge[0], (i == 10));
      chk("clean_pressed", pressed[0], (i >= 10));
      chk("clean_ch1_quiet", {pressed[1], bedge[1], brel[1], lp[1], hld[1], rep[1]}, 0);
    end

    // Long press with repeat on channel 1, release at cycle 60
    button = 2'b00;
    do_reset();
    @(negedge clk);
    button = 2'b10;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      chk($sformatf("long_seq_c%0d", i), {bedge[1], lp[1], hld[1], rep[1], brel[1]},
          {(i == 10), (i == 30), (i >= 30 && i < 70),
           (i >= 35 && i < 70 && ((i - 30) % 5) == 0), (i == 70)});
      if (i == 60) button = 2'b00;
    end

    // Bounce: toggle every 3 cycles for 40 cycles, final rise at cycle 40
    do_reset();
    b0 = 1'b0; n_edge = 0; edge_at = -1;
    for (int i = 0; i < 70; i++) begin
      if (i < 40) begin
        if ((i % 3) == 0) b0 = ~b0;
      end else begin
        b0 = 1'b1;
      end
      button = {1'b0, b0};
      @(negedge clk);
      if (bedge[0]) begin n_edge++; edge_at = i + 1; end
    end
    chk("bounce_edge_count", n_edge, 1);
    chk("bounce_edge_cycle", edge_at, 50);

    // Short press: 15 cycles high
    button = 2'b00;
    do_reset();
    n_edge = 0; n_rel = 0; n_long = 0; n_held = 0; edge_at = -1; rel_at = -1;
    for (int i = 0; i < 45; i++) begin
      button = {1'b0, (i < 15)};
      @(negedge clk);
      if (bedge[0]) begin n_edge++; edge_at = i + 1; end
      if (brel[0])  begin n_rel++;  rel_at  = i + 1; end
      if (lp[0])  n_long++;
      if (hld[0]) n_held++;
    end
    chk("short_edge_cycle", edge_at, 10);
    chk("short_rel_cycle", rel_at, 25);
    chk("short_counts", {n_edge[7:0], n_rel[7:0], n_long[7:0], n_held[7:0]}, 32'h01010000);

    // Reset in the middle of a hold
    button = 2'b00;
    do_reset();
    button = 2'b01;
    cyc(25);
    chk("midhold_pressed", {pressed[0], hld[0]}, 2'b10);
    #2 rst_n = 1'b0;
    #1 chk("midhold_async_clear", {pressed, bedge, brel, lp, hld, rep}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n_rel = 0; edge_at = -1; long_at = -1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (bedge[0] && edge_at < 0) edge_at = i;
      if (lp[0] && long_at < 0)    long_at = i;
      if (brel[0]) n_rel++;
    end
    chk("midhold_new_edge", edge_at, 10);
    chk("midhold_long", long_at, 30);
    chk("midhold_no_release", n_rel, 0);

    // Randomised runs, checked every cycle by the model
    button = 2'b00;
    do_reset();
    for (int c = 0; c < N; c++) begin rb[c] = 1'b0; run_left[c] = 0; end
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (run_left[c] == 0) begin
          rb[c] = ~rb[c];
          run_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 90))
                                                     : int'($urandom_range(1, 12));
        end
        run_left[c]--;
      end
      button = {rb[1], rb[0]};
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    // Active-low instance, long debounce window, repeat disabled
    button = 2'b00;
    al_button = 1'b1;
    do_reset();
    al_button = 1'b0;
    cyc(1000);
    chk("al_after_1000", al_pressed, 0);
    al_button = 1'b1;
    cyc(100);
    chk("al_after_1100", al_pressed, 0);
    al_button = 1'b0;
    al_rise_at = -1; al_rep_seen = 0; al_edges = 0;
    for (int i = 1; i <= 2550; i++) begin
      @(negedge clk);
      if (al_pressed[0] && al_rise_at < 0) al_rise_at = i;
      if (al_rep[0])  al_rep_seen++;
      if (al_edge[0]) al_edges++;
      if (al_rel[0] || (al_lp[0] && i < 2522)) al_rep_seen++;
    end
    chk("al_rise_cycle", al_rise_at, 2502);
    chk("al_final", {al_pressed[0], al_held[0]}, 2'b11);
    chk("al_edges", al_edges, 1);
    chk("al_no_stray_pulses", al_rep_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
